udma_hyper_tx_prefetch: RTL and testbench



---
 rtl/udma_hyper_tx_prefetch.sv | 165 ++++++++++++++++
 tb/tb_udma_hyper_tx_prefetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_hyper_tx_prefetch.sv
// uDMA TX prefetch: credit-throttled read requests into a small FWFT FIFO.
// Define HYPER_TX_PREFETCH_ERR_EN to build the sticky protocol-error flag.
module udma_hyper_tx_prefetch #(
  parameter int DEPTH      = 4,
  parameter int TRANS_SIZE = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [TRANS_SIZE-1:0] cfg_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  data_tx_req_o,
  input  logic                  data_tx_gnt_i,
  input  logic [31:0]           data_tx_i,
  input  logic                  data_tx_valid_i,
  output logic                  data_tx_ready_o,
  output logic [31:0]           tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TRANS_SIZE-1:0] T_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [TRANS_SIZE-1:0] req_left;
  logic [TRANS_SIZE-1:0] pop_left;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fill;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0] mem [DEPTH];

  logic [CW:0] credit_sum;
  logic grant;
  logic ret;
  logic push;
  logic pop;
  logic start_ok;

  assign credit_sum = {1'b0, fill} + {1'b0, outstanding};
  assign grant = data_tx_req_o && data_tx_gnt_i;
  assign ret = data_tx_valid_i && (outstanding != '0);
  // Returns seen in IDLE belong to a flushed burst and are dropped.
  assign push = ret && (state != IDLE);
  assign pop = tx_valid_o && tx_ready_i;
  assign start_ok = start_i && (outstanding == '0);

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok)
            state_nxt = (cfg_words_i != '0) ? FETCH : DONE;
        end
        FETCH: begin
          if (grant && req_left == T_ONE) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (pop && pop_left == T_ONE) state_nxt = DONE;
        end
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
    data_tx_req_o = (state == FETCH) && (req_left != '0) &&
                    (credit_sum < DEPTH_V);
  end

  assign data_tx_ready_o = 1'b1;
  assign tx_valid_o = (fill != '0);
  assign tx_data_o = mem[rd_ptr];

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      unique case ({grant, ret})
        2'b10: outstanding <= outstanding + C_ONE;
        2'b01: outstanding <= outstanding - C_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_left <= '0;
      pop_left <= '0;
      fill <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_i) begin
      req_left <= '0;
      pop_left <= '0;
      fill <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state == IDLE && start_ok) begin
        req_left <= cfg_words_i;
        pop_left <= cfg_words_i;
      end else begin
        if (grant) req_left <= req_left - T_ONE;
        if (pop) pop_left <= pop_left - T_ONE;
      end
      if (push) begin
        mem[wr_ptr] <= data_tx_i;
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + P_ONE;
      unique case ({push, pop})
        2'b10: fill <= fill + C_ONE;
        2'b01: fill <= fill - C_ONE;
        default: fill <= fill;
      endcase
    end
  end

`ifdef HYPER_TX_PREFETCH_ERR_EN
  logic err_q;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if ((data_tx_valid_i && outstanding == '0) ||
             (data_tx_gnt_i && !data_tx_req_o))
      err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_udma_hyper_tx_prefetch.sv
// Bench for udma_hyper_tx_prefetch: random uDMA slave plus
// an in-order scoreboard of the words each burst must deliver.
module tb_udma_hyper_tx_prefetch;

  localparam int DEPTH = 4;
  localparam int TS = 16;
`ifdef HYPER_TX_PREFETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i;
  logic clr_i;
  logic start_i;
  logic [TS-1:0] cfg_words;
  logic busy_o;
  logic done_o;
  logic data_tx_req_o;
  logic data_tx_gnt_i;
  logic [31:0] data_tx_i;
  logic data_tx_valid_i;
  logic data_tx_ready_o;
  logic [31:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i;
  logic err_o;

  udma_hyper_tx_prefetch #(.DEPTH(DEPTH), .TRANS_SIZE(TS)) dut (
    .sys_clk_i(clk),
    .rst_i(rst_i),
    .clr_i(clr_i),
    .start_i(start_i),
    .cfg_words_i(cfg_words),
    .busy_o(busy_o),
    .done_o(done_o),
    .data_tx_req_o(data_tx_req_o),
    .data_tx_gnt_i(data_tx_gnt_i),
    .data_tx_i(data_tx_i),
    .data_tx_valid_i(data_tx_valid_i),
    .data_tx_ready_o(data_tx_ready_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    logic [31:0] d;
  } ret_t;

  ret_t ret_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gr_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int last_due = 0;
  int grant_limit = 1 << 30;
  int gnt_pct = 100;
  int ready_pct = 100;
  int lat_min = 2;
  int lat_max = 2;
  bit stray = 1'b0;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // uDMA slave: grants at random, returns data in order after a latency.
  always @(negedge clk) begin
    bit g;
    int due;
    logic [31:0] w;
    cyc++;
    if (rst_i) begin
      data_tx_gnt_i = 1'b0;
      data_tx_valid_i = 1'b0;
      data_tx_i = '0;
      tx_ready_i = 1'b0;
    end else begin
      g = data_tx_req_o && (gr_cnt < grant_limit) &&
          ($urandom_range(99) < gnt_pct);
      data_tx_gnt_i = g;
      if (g) begin
        gr_cnt++;
        check("credit_owed_le_depth", 32'((gr_cnt - pop_cnt) <= DEPTH), 1);
        w = $urandom;
        exp_q.push_back(w);
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_q.push_back('{due, w});
      end
      if (stray) begin
        data_tx_valid_i = 1'b1;
        data_tx_i = 32'hdead_beef;
        stray = 1'b0;
      end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        data_tx_valid_i = 1'b1;
        data_tx_i = ret_q[0].d;
        ret_q.delete(0);
      end else begin
        data_tx_valid_i = 1'b0;
        data_tx_i = $urandom;
      end
      tx_ready_i = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: every accepted head word must match the scoreboard.
  always @(negedge clk) begin
    #2;
    if (!rst_i) begin
      if (tx_valid_o && tx_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_expected: got word %0h expected none", tx_data_o);
        end else begin
          check("tx_data", tx_data_o, exp_q.pop_front());
        end
      end
      if (done_o) done_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(int words);
    @(negedge clk);
    start_i = 1'b1;
    cfg_words = words[TS-1:0];
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic finish_burst(int words, string tag, int d0);
    int n = 0;
    while (!done_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 5000), 1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy_o), 0);
    check({tag, "_done_low"}, 32'(done_o), 0);
    check({tag, "_pops"}, pop_cnt, words);
    check({tag, "_grants"}, gr_cnt, words);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_done_once"}, done_cnt, d0 + 1);
  endtask

  task automatic run_burst(int words, string tag);
    int d0;
    gr_cnt = 0;
    pop_cnt = 0;
    d0 = done_cnt;
    pulse_start(words);
    finish_burst(words, tag, d0);
  endtask

  initial begin
    int n;
    int d0;
    rst_i = 1'b1;
    clr_i = 1'b0;
    start_i = 1'b0;
    cfg_words = '0;
    data_tx_gnt_i = 1'b0;
    data_tx_valid_i = 1'b0;
    data_tx_i = '0;
    tx_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_req", 32'(data_tx_req_o), 0);
    check("rst_tx_valid", 32'(tx_valid_o), 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_ready", 32'(data_tx_ready_o), 1);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    run_burst(8, "basic");

    gr_cnt = 0;
    pop_cnt = 0;
    ready_pct = 0;
    d0 = done_cnt;
    pulse_start(8);
    repeat (20) @(negedge clk);
    check("bp_grants", gr_cnt, DEPTH);
    check("bp_req_low", 32'(data_tx_req_o), 0);
    check("bp_tx_valid", 32'(tx_valid_o), 1);
    check("bp_no_pops", pop_cnt, 0);
    ready_pct = 100;
    finish_burst(8, "bp", d0);

    d0 = done_cnt;
    gr_cnt = 0;
    pulse_start(0);
    check("zero_done", 32'(done_o), 1);
    check("zero_req", 32'(data_tx_req_o), 0);
    @(negedge clk);
    check("zero_done_low", 32'(done_o), 0);
    check("zero_busy", 32'(busy_o), 0);
    check("zero_grants", gr_cnt, 0);
    #3;
    check("zero_done_cnt", done_cnt, d0 + 1);

    gr_cnt = 0;
    pop_cnt = 0;
    grant_limit = 2;
    lat_min = 8;
    lat_max = 8;
    pulse_start(8);
    n = 0;
    while (gr_cnt < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("flush_grants", gr_cnt, 2);
    clr_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clr_i = 1'b0;
    check("flush_busy", 32'(busy_o), 0);
    check("flush_tx_valid", 32'(tx_valid_o), 0);
    check("flush_pending", 32'(ret_q.size() > 0), 1);
    pulse_start(5);
    check("flush_start_ignored", 32'(busy_o), 0);
    check("flush_req_low", 32'(data_tx_req_o), 0);
    n = 0;
    while (ret_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("flush_discard", 32'(tx_valid_o), 0);
    check("flush_busy_after", 32'(busy_o), 0);
    grant_limit = 1 << 30;
    lat_min = 2;
    lat_max = 2;
    run_burst(6, "post_flush");

    lat_min = 1;
    lat_max = 1;
    ready_pct = 75;
    run_burst(24, "simul");

    for (int i = 0; i < 6; i++) begin
      gnt_pct = int'($urandom_range(100, 30));
      ready_pct = int'($urandom_range(100, 20));
      lat_min = int'($urandom_range(3, 1));
      lat_max = lat_min + int'($urandom_range(4, 0));
      run_burst(int'($urandom_range(30, 1)), "rand");
    end

    @(posedge clk);
    stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stray_err", 32'(err_o), 32'(ERR_EN));
    check("stray_no_push", 32'(tx_valid_o), 0);
    repeat (3) @(negedge clk);
    check("stray_err_sticky", 32'(err_o), 32'(ERR_EN));
    check("stray_idle", 32'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
